// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback commit unit: result source tag, queued
// result entry and the hard-wired zero register index.
package wb_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    wb_src_e         src;
  } wb_entry_t;

endpackage

// File: rtl/wb_commit_fifo.sv
// Synchronous result FIFO for the writeback commit unit. Holds results that
// were accepted while the commit slot was occupied and stalled. Push and pop
// in the same cycle are allowed even when full, since the pop frees the slot
// the push lands in.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t pop_data,
  output logic [AW:0] count,
  output logic      empty,
  output logic      full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit unit: merges ALU and LSU results into the single register
// file write port in acceptance order, buffers results across writeback
// stalls, and tracks destinations of in-flight long-latency instructions.
// XLEN must equal wb_pkg::XLEN, which sizes the queued entry.
module wb_commit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [4:0]      i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  input  logic            i_wb_stall,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren,
  output logic [31:0]     o_busy,
  output logic [CW-1:0]   o_count
);

  // ---- stage p0: arbitration and acceptance ----
  logic      rr_flag;
  logic      space_p0;
  logic      grant_alu_p0;
  logic      grant_lsu_p0;
  logic      alu_hs_p0;
  logic      lsu_hs_p0;
  logic      vld_p0;
  wb_entry_t entry_p0;

  // FIFO interface
  logic      fifo_push;
  logic      fifo_pop;
  wb_entry_t fifo_head;
  logic      fifo_empty;
  logic      fifo_full;

  // ---- stage p1: commit slot ----
  logic      vld_p1;
  wb_entry_t slot_p1;
  logic      slot_free;
  logic      bypass;
  logic      commit_lsu;
  logic [31:0] busy_next;

  // Full is derived from the registered occupancy, so a same-cycle pop never raises ready.
  assign space_p0 = ~fifo_full;

  assign grant_alu_p0 = i_alu_valid & (~i_lsu_valid | ~rr_flag);
  assign grant_lsu_p0 = i_lsu_valid & (~i_alu_valid |  rr_flag);

  assign o_alu_ready = grant_alu_p0 & space_p0 & i_rst_n;
  assign o_lsu_ready = grant_lsu_p0 & space_p0 & i_rst_n;

  assign alu_hs_p0 = i_alu_valid & o_alu_ready;
  assign lsu_hs_p0 = i_lsu_valid & o_lsu_ready;

  // Select the accepted payload; grants are mutually exclusive.
  always_comb begin
    entry_p0 = '0;
    if (lsu_hs_p0) begin
      entry_p0.rd   = i_lsu_rd;
      entry_p0.data = i_lsu_data;
      entry_p0.src  = SRC_LSU;
    end else begin
      entry_p0.rd   = i_alu_rd;
      entry_p0.data = i_alu_data;
      entry_p0.src  = SRC_ALU;
    end
  end

  // x0 results complete their handshake but are dropped here.
  assign vld_p0 = (alu_hs_p0 | lsu_hs_p0) & (entry_p0.rd != REG_ZERO);

  // Slot moves when empty or when its current entry is being written this cycle.
  assign slot_free = ~vld_p1 | ~i_wb_stall;
  assign fifo_pop  = slot_free & ~fifo_empty;
  assign bypass    = slot_free &  fifo_empty & vld_p0;
  assign fifo_push = vld_p0 & ~bypass;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (fifo_push),
    .push_data (entry_p0),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (o_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Round-robin pointer: flips only when both sources competed and one won.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_flag <= 1'b0;
    end else if (i_alu_valid & i_lsu_valid & space_p0) begin
      rr_flag <= ~rr_flag;
    end
  end

  // ---- stage p1 boundary: commit slot register ----
  // Commit slot: head of queue first, otherwise the fresh result, otherwise empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      slot_p1 <= '0;
    end else if (slot_free) begin
      if (fifo_pop) begin
        vld_p1  <= 1'b1;
        slot_p1 <= fifo_head;
      end else if (bypass) begin
        vld_p1  <= 1'b1;
        slot_p1 <= entry_p0;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign o_rd_addr  = slot_p1.rd;
  assign o_rd_data  = slot_p1.data;
  assign o_rd_wren  = vld_p1 & ~i_wb_stall;
  assign commit_lsu = o_rd_wren & (slot_p1.src == SRC_LSU);

  // Scoreboard update: clear on LSU commit, then set on issue so set wins.
  always_comb begin
    busy_next = o_busy;
    if (commit_lsu) begin
      busy_next[slot_p1.rd] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != REG_ZERO)) begin
      busy_next[i_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Pending-destination scoreboard register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy <= '0;
    end else begin
      o_busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Directed testbench for wb_commit: reset, single result, contention,
// stall fill/drain, scoreboard, x0 results and asynchronous mid-stream reset.
module tb_wb_commit;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_stall;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
  logic [31:0] busy;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  wb_commit #(
    .DEPTH (4),
    .XLEN  (32)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_alu_valid   (alu_valid),
    .o_alu_ready   (alu_ready),
    .i_alu_rd      (alu_rd),
    .i_alu_data    (alu_data),
    .i_lsu_valid   (lsu_valid),
    .o_lsu_ready   (lsu_ready),
    .i_lsu_rd      (lsu_rd),
    .i_lsu_data    (lsu_data),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_wb_stall    (wb_stall),
    .o_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_wren     (rd_wren),
    .o_busy        (busy),
    .o_count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd7;
    alu_data    = 32'h55;
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd6;
    lsu_data    = 32'h66;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    wb_stall    = 1'b0;

    // Reset state
    #2;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_wren", 32'(rd_wren), 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_addr", 32'(rd_addr), 32'd0);
    chk("reset_data", rd_data, 32'd0);
    chk("reset_alu_ready", 32'(alu_ready), 32'd0);
    chk("reset_lsu_ready", 32'(lsu_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;

    // Single ALU result bypasses straight into the slot
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    mid();
    chk("t1_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    mid();
    chk("t1_wren", 32'(rd_wren), 32'd1);
    chk("t1_addr", 32'(rd_addr), 32'd5);
    chk("t1_data", rd_data, 32'h1234);
    chk("t1_count", 32'(count), 32'd0);
    tick();
    mid();
    chk("t1_idle_wren", 32'(rd_wren), 32'd0);

    // Contention: ALU first, then LSU, then ALU again
    tick();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB;
    mid();
    chk("t2_alu_ready0", 32'(alu_ready), 32'd1);
    chk("t2_lsu_ready0", 32'(lsu_ready), 32'd0);
    tick();
    alu_rd = 5'd10; alu_data = 32'hC;
    mid();
    chk("t2_alu_ready1", 32'(alu_ready), 32'd0);
    chk("t2_lsu_ready1", 32'(lsu_ready), 32'd1);
    chk("t2_commit1_wren", 32'(rd_wren), 32'd1);
    chk("t2_commit1_addr", 32'(rd_addr), 32'd1);
    chk("t2_commit1_data", rd_data, 32'hA);
    tick();
    lsu_valid = 1'b0;
    mid();
    chk("t2_alu_ready2", 32'(alu_ready), 32'd1);
    chk("t2_commit2_addr", 32'(rd_addr), 32'd2);
    chk("t2_commit2_data", rd_data, 32'hB);
    tick();
    alu_valid = 1'b0;
    mid();
    chk("t2_commit3_addr", 32'(rd_addr), 32'd10);
    chk("t2_commit3_data", rd_data, 32'hC);
    tick();
    mid();
    chk("t2_idle_wren", 32'(rd_wren), 32'd0);

    // Stall fill: slot holds rd=3, FIFO fills with rd=4..7, rd=8 held off
    wb_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      alu_valid = 1'b1; alu_rd = 5'(3 + i); alu_data = 32'h300 + 32'(3 + i);
      mid();
      chk("t3_fill_count", 32'(count), (i == 0) ? 32'd0 : 32'(i - 1));
      chk("t3_fill_ready", 32'(alu_ready), (i < 5) ? 32'd1 : 32'd0);
      chk("t3_fill_wren", 32'(rd_wren), 32'd0);
    end
    chk("t3_slot_addr", 32'(rd_addr), 32'd3);
    tick();
    wb_stall = 1'b0;
    mid();
    chk("t3_rel_ready", 32'(alu_ready), 32'd0);
    chk("t3_rel_count", 32'(count), 32'd4);
    chk("t3_commit_wren", 32'(rd_wren), 32'd1);
    chk("t3_commit_addr", 32'(rd_addr), 32'd3);
    tick();
    mid();
    chk("t3_ready_after_pop", 32'(alu_ready), 32'd1);
    chk("t3_commit_addr", 32'(rd_addr), 32'd4);
    tick();
    alu_valid = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      mid();
      chk("t3_commit_wren", 32'(rd_wren), 32'd1);
      chk("t3_commit_addr", 32'(rd_addr), 32'(k));
      chk("t3_commit_data", rd_data, 32'h300 + 32'(k));
      chk("t3_drain_count", 32'(count), (k == 5) ? 32'd3 : 32'(8 - k));
      tick();
    end
    mid();
    chk("t3_idle_wren", 32'(rd_wren), 32'd0);

    // Scoreboard set then clear by LSU commit
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9;
    mid();
    chk("t4_busy_before", 32'(busy[9]), 32'd0);
    tick();
    issue_valid = 1'b0;
    mid();
    chk("t4_busy_set", 32'(busy[9]), 32'd1);
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    mid();
    chk("t4_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    mid();
    chk("t4_commit_addr", 32'(rd_addr), 32'd9);
    chk("t4_commit_wren", 32'(rd_wren), 32'd1);
    chk("t4_busy_during", 32'(busy[9]), 32'd1);
    tick();
    mid();
    chk("t4_busy_clear", 32'(busy[9]), 32'd0);

    // Issue and commit of the same rd in the same cycle: set wins
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h77;
    tick();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    mid();
    chk("t4b_commit_addr", 32'(rd_addr), 32'd9);
    chk("t4b_commit_wren", 32'(rd_wren), 32'd1);
    tick();
    issue_valid = 1'b0;
    mid();
    chk("t4b_busy_kept", busy, 32'h0000_0200);

    // rd=0: handshake completes, nothing committed, scoreboard untouched
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    mid();
    chk("t5_ready", 32'(alu_ready), 32'd1);
    chk("t5_count0", 32'(count), 32'd0);
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b0;
    mid();
    chk("t5_wren", 32'(rd_wren), 32'd0);
    chk("t5_count1", 32'(count), 32'd0);
    chk("t5_busy", busy, 32'h0000_0200);

    // Mid-stream asynchronous reset with three entries queued
    tick();
    wb_stall = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB11;
    tick();
    issue_valid = 1'b0;
    alu_rd = 5'd12; alu_data = 32'hB12;
    tick();
    alu_rd = 5'd13; alu_data = 32'hB13;
    tick();
    alu_rd = 5'd14; alu_data = 32'hB14;
    tick();
    alu_valid = 1'b0;
    mid();
    chk("t6_count_pre", 32'(count), 32'd3);
    chk("t6_busy_pre", busy, 32'h0000_0210);
    #2;
    rst_n    = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_wren", 32'(rd_wren), 32'd0);
    chk("t6_rst_busy", busy, 32'd0);
    chk("t6_rst_addr", 32'(rd_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      mid();
      chk("t6_post_wren", 32'(rd_wren), 32'd0);
      chk("t6_post_count", 32'(count), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit for the RV32 core. It is the writer side of the register file: it merges results from the single-cycle ALU and the multi-cycle load/store unit (LSU) into the register file's single write port, preserving acceptance order. It absorbs writeback stalls in a small FIFO and keeps a pending-destination scoreboard that the hazard logic uses for load-use stalls.

## Interface
- DEPTH, 4: result FIFO entries (power of two, ≥2)
- XLEN, 32: data width

- i_clk  in  1  clock; all state updates on posedge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU result accepted this cycle
- i_alu_rd  in  5  ALU destination
- i_alu_data  in  XLEN  ALU result
- i_lsu_valid  in  1  LSU result valid
- o_lsu_ready  out  1  LSU result accepted this cycle
- i_lsu_rd  in  5  LSU destination
- i_lsu_data  in  XLEN  load data
- i_issue_valid  in  1  long-latency (LSU) instruction issued
- i_issue_rd  in  5  its destination
- i_wb_stall  in  1  inhibit commit this cycle
- o_rd_addr  out  5  register file write address
- o_rd_data  out  XLEN  register file write data
- o_rd_wren  out  1  register file write enable
- o_busy  out  32  pending LSU destinations; bit 0 always 0
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Commit slot: a registered {valid, rd, data, src} entry. o_rd_addr and o_rd_data come from the slot. o_rd_wren = slot_valid & ~i_wb_stall.
- Slot frees this cycle when ~slot_valid | ~i_wb_stall. When it frees, it loads the FIFO head (pop) if the FIFO is non-empty. Otherwise it loads the accepted input (bypass). Otherwise it becomes invalid.
- An accepted input that is not bypassed is pushed into the FIFO. Bypass is allowed only when the FIFO is empty, so order is preserved.
- Space: space = (o_count < DEPTH), evaluated on the registered count. A pop in the same cycle does not raise ready.
- Arbitration: round-robin between ALU and LSU. rr_flag = 0 gives the ALU priority. When both are valid and space exists, the priority source is granted and rr_flag flips at the edge. A lone valid source is granted without changing rr_flag.
- Ready: o_x_ready = grant_x & space. Handshake completes on valid & ready. Valid and payload must stay stable until ready.
- rd = 0 results: accepted normally (ready per the rules above), then discarded. They are never enqueued or committed.
- Scoreboard:
  - i_issue_valid with i_issue_rd ≠ 0 sets o_busy[rd].
  - A committed LSU-sourced entry (o_rd_wren = 1, src = LSU) clears o_busy[rd] at that edge.
  - Set and clear of the same rd in the same cycle: set wins.
  - Issue to an already-busy rd leaves the bit at 1. The hazard unit must prevent this.
- Reset: slot invalid, FIFO empty, o_count = 0, o_busy = 0, rr_flag = 0, o_rd_addr = 0, o_rd_data = 0, o_rd_wren = 0, both readies 0. Reset mid-operation drops all pending results and the scoreboard.

## Timing
- Latency: a handshake at edge N with an empty FIFO and a free slot gives o_rd_wren = 1 during cycle N+1. Each queued entry adds one cycle.
- Throughput: one accept and one commit per cycle.
- o_rd_addr and o_rd_data change only on posedge. They are stable across the negedge at which the register file captures the write. o_rd_wren is combinational from i_wb_stall, which must come from a posedge flop.
- Readies are combinational from valids, rr_flag and the registered count. There is no valid→ready→valid loop.
- o_busy is registered: a set is visible the cycle after issue, and a clear is visible the cycle after commit.

## Structure
- Shared package wb_pkg:
  - typedef wb_src_e {SRC_ALU, SRC_LSU}
  - typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data; wb_src_e src;}
  - constant REG_ZERO = 5'd0
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, DEPTH entries, push/pop/count/empty/full, simultaneous push and pop allowed at full.
- Arbiter, slot and scoreboard live in wb_commit.

## Test plan
- Single ALU result: rd=5, data=0x1234 with idle FIFO → o_rd_wren=1, o_rd_addr=5, o_rd_data=0x1234 the next cycle; o_count stays 0.
- Contention: ALU (rd=1, 0xA) and LSU (rd=2, 0xB) both valid for 2 cycles from reset → ALU accepted first, then LSU; commits rd=1 then rd=2.
- Stall fill: i_wb_stall=1 for 6 cycles with the ALU streaming rd=3..8 →
  - slot holds rd=3 and the FIFO fills to 4 entries (rd=4..7);
  - o_alu_ready=0 while the FIFO is full (rd=8 held off);
  - on release, commits occur in order 3,4,5,6,7,8 on consecutive cycles.
- Scoreboard:
  - issue rd=9 → o_busy[9]=1 the next cycle.
  - LSU result for rd=9 commits → o_busy[9]=0 the cycle after the commit.
  - issue rd=9 in the same cycle as the commit of rd=9 → o_busy[9] stays 1.
- rd=0 result: ALU rd=0, data=0xFFFF → ready=1, no o_rd_wren, o_count unchanged; issue rd=0 leaves o_busy=0.
- Reset mid-stream: assert i_rst_n=0 with 3 entries queued and o_busy[4]=1 → asynchronously o_count=0, o_rd_wren=0, o_busy=0; no stale commit after release.
